// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads one big-endian word per cycle and queues {PC, instruction} for decode.
// Optional build macro FETCH_ZERO_HALT_EN: stop fetching on an all-zero word until redirect or reset.
module instruction_fetch_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] Instruction_Address,
  input  logic [31:0] Instruction,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  output logic        Fetch_Valid,
  input  logic        Fetch_Ready,
  output logic [31:0] Fetch_Instruction,
  output logic [31:0] Fetch_PC,
  output logic        Halted
);

  localparam int          PTR_W     = $clog2(DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  // Handshake: decode takes the head on a cycle where Fetch_Valid && Fetch_Ready;
  // Fetch_Valid never depends on Fetch_Ready, and the head holds until taken.

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      mem_q [DEPTH];
  logic [63:0]      mem_d [DEPTH];

  logic halted;
  logic zero_word;
  logic pop;
  logic push_slot;
  logic push;

  assign Instruction_Address = pc_q;
  assign Fetch_Valid         = (count_q != '0);
  assign Fetch_PC            = mem_q[rd_ptr_q][63:32];
  assign Fetch_Instruction   = mem_q[rd_ptr_q][31:0];

  assign pop       = Fetch_Valid && Fetch_Ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push_slot = !Redirect_Valid && !halted && ((count_q < CNT_W'(DEPTH)) || pop);
  assign push      = push_slot && !zero_word;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (Redirect_Valid) begin
      pc_d     = {Redirect_Target[31:2], 2'b00} & ADDR_MASK;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {pc_q, Instruction};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        pc_d            = (pc_q + 32'd4) & ADDR_MASK;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC & ADDR_MASK;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

`ifdef FETCH_ZERO_HALT_EN
  logic halted_q, halted_d;

  assign zero_word = (Instruction == 32'h0);
  assign halted    = halted_q;
  assign Halted    = halted_q;

  // The zero word is never queued; the PC stays on it so a debugger sees where fetch stopped.
  always_comb begin
    halted_d = halted_q;
    if (Redirect_Valid) begin
      halted_d = 1'b0;
    end else if (push_slot && zero_word) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`else
  assign zero_word = 1'b0;
  assign halted    = 1'b0;
  assign Halted    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 128-byte big-endian memory model and hand-computed expectations.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] Instruction_Address;
  logic [31:0] Instruction;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        Fetch_Valid;
  logic        Fetch_Ready;
  logic [31:0] Fetch_Instruction;
  logic [31:0] Fetch_PC;
  logic        Halted;

  logic [7:0] mem [128];

  int pass_cnt;
  int total_cnt;

  instruction_fetch_unit #(
    .DEPTH     (4),
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (128)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Instruction_Address (Instruction_Address),
    .Instruction         (Instruction),
    .Redirect_Valid      (Redirect_Valid),
    .Redirect_Target     (Redirect_Target),
    .Fetch_Valid         (Fetch_Valid),
    .Fetch_Ready         (Fetch_Ready),
    .Fetch_Instruction   (Fetch_Instruction),
    .Fetch_PC            (Fetch_PC),
    .Halted              (Halted)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory model: same-cycle big-endian read
  always_comb begin
    logic [6:0] a;
    a = Instruction_Address[6:0];
    Instruction = {mem[a], mem[7'(a + 7'd1)], mem[7'(a + 7'd2)], mem[7'(a + 7'd3)]};
  end

  task automatic set_word(input int addr, input logic [31:0] w);
    mem[addr]     = w[31:24];
    mem[addr + 1] = w[23:16];
    mem[addr + 2] = w[15:8];
    mem[addr + 3] = w[7:0];
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    Redirect_Valid  = 1'b1;
    Redirect_Target = target;
    step(1);
    Redirect_Valid  = 1'b0;
    Redirect_Target = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    rst             = 1'b1;
    Redirect_Valid  = 1'b0;
    Redirect_Target = 32'h0;
    Fetch_Ready     = 1'b0;
    for (int a = 0; a < 128; a += 4) begin
      set_word(a, 32'hA500_0000 | 32'(a));
    end
    set_word(0, 32'h0102_0302);
    set_word(4, 32'hC003_0002);

    // reset values
    @(negedge clk);
    step(2);
    check("rst_addr", Instruction_Address, 32'h0);
    check("rst_valid", 32'(Fetch_Valid), 32'h0);
    check("rst_halted", 32'(Halted), 32'h0);
    check("rst_fpc", Fetch_PC, 32'h0);
    check("rst_finstr", Fetch_Instruction, 32'h0);

    // streaming with ready high
    rst         = 1'b0;
    Fetch_Ready = 1'b1;
    step(1);
    check("s0_valid", 32'(Fetch_Valid), 32'h1);
    check("s0_pc", Fetch_PC, 32'h0);
    check("s0_instr", Fetch_Instruction, 32'h0102_0302);
    step(1);
    check("s1_pc", Fetch_PC, 32'h4);
    check("s1_instr", Fetch_Instruction, 32'hC003_0002);
    check("s1_addr", Instruction_Address, 32'h8);

    // back-pressure fills the queue
    rst         = 1'b1;
    Fetch_Ready = 1'b0;
    step(1);
    rst = 1'b0;
    step(10);
    check("full_addr", Instruction_Address, 32'h10);
    check("full_valid", 32'(Fetch_Valid), 32'h1);
    check("full_head", Fetch_PC, 32'h0);

    // drain in order, push continues while full
    Fetch_Ready = 1'b1;
    step(1);
    check("d0_pc", Fetch_PC, 32'h4);
    check("d0_addr", Instruction_Address, 32'h14);
    step(1);
    check("d1_pc", Fetch_PC, 32'h8);
    step(1);
    check("d2_pc", Fetch_PC, 32'hC);
    step(1);
    check("d3_pc", Fetch_PC, 32'h10);
    check("d3_instr", Fetch_Instruction, 32'hA500_0010);
    check("d3_addr", Instruction_Address, 32'h20);
    Fetch_Ready = 1'b0;
    step(2);
    check("still_full_addr", Instruction_Address, 32'h20);
    check("still_full_head", Fetch_PC, 32'h10);

    // redirect with three queued
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    check("q3_addr", Instruction_Address, 32'hC);
    redirect(32'h0000_000A);
    check("rd_valid0", 32'(Fetch_Valid), 32'h0);
    check("rd_addr", Instruction_Address, 32'h8);
    step(1);
    check("rd_valid1", 32'(Fetch_Valid), 32'h1);
    check("rd_pc", Fetch_PC, 32'h8);
    check("rd_instr", Fetch_Instruction, 32'hA500_0008);

    // wrap at top of memory
    Fetch_Ready = 1'b1;
    redirect(32'd124);
    check("w_valid0", 32'(Fetch_Valid), 32'h0);
    check("w_addr", Instruction_Address, 32'd124);
    step(1);
    check("w_pc124", Fetch_PC, 32'd124);
    check("w_instr124", Fetch_Instruction, 32'hA500_007C);
    check("w_addr0", Instruction_Address, 32'h0);
    step(1);
    check("w_pc0", Fetch_PC, 32'h0);
    check("w_instr0", Fetch_Instruction, 32'h0102_0302);

    // high target bits are masked off
    redirect(32'hFFFF_FF86);
    check("mask_addr", Instruction_Address, 32'h4);

    // reset overrides redirect/pop with a full queue
    Fetch_Ready = 1'b0;
    step(5);
    check("pre_rst_valid", 32'(Fetch_Valid), 32'h1);
    rst             = 1'b1;
    Fetch_Ready     = 1'b1;
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h40;
    step(1);
    rst             = 1'b0;
    Redirect_Valid  = 1'b0;
    Fetch_Ready     = 1'b0;
    check("mr_valid", 32'(Fetch_Valid), 32'h0);
    check("mr_addr", Instruction_Address, 32'h0);
    check("mr_fpc", Fetch_PC, 32'h0);
    check("mr_finstr", Fetch_Instruction, 32'h0);

    // zero word at address 8
    set_word(8, 32'h0);
    Fetch_Ready = 1'b1;
    redirect(32'h0);
    step(1);
    check("z_pc0", Fetch_PC, 32'h0);
    step(1);
    check("z_pc4", Fetch_PC, 32'h4);
    check("z_addr8", Instruction_Address, 32'h8);
    step(1);
`ifdef FETCH_ZERO_HALT_EN
    check("z_valid", 32'(Fetch_Valid), 32'h0);
    check("z_halted", 32'(Halted), 32'h1);
    check("z_hold_addr", Instruction_Address, 32'h8);
    step(2);
    check("z_halted_hold", 32'(Halted), 32'h1);
    check("z_addr_hold2", Instruction_Address, 32'h8);
    check("z_valid_hold", 32'(Fetch_Valid), 32'h0);
    redirect(32'h0);
    check("z_unhalt", 32'(Halted), 32'h0);
    check("z_unhalt_addr", Instruction_Address, 32'h0);
    step(1);
    check("z_resume_pc", Fetch_PC, 32'h0);
`else
    check("z_valid", 32'(Fetch_Valid), 32'h1);
    check("z_pc8", Fetch_PC, 32'h8);
    check("z_instr8", Fetch_Instruction, 32'h0);
    check("z_halted", 32'(Halted), 32'h0);
    check("z_addr12", Instruction_Address, 32'hC);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
